// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - MIPS-I execute stage: ALU-control decode, 32-bit ALU with HI/LO, branch-target adder
// Optional feature macro: ALU_MULDIV_EN (multiply/divide datapath and HI/LO update path)
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] immdt_32,
  input  logic [31:0] pc_plus4,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] branch_addr,
  output logic [4:0]  alu_ctrl
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLT   = 5'd5;
  localparam logic [4:0] OP_SLTU  = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_SLLV  = 5'd10;
  localparam logic [4:0] OP_SRLV  = 5'd11;
  localparam logic [4:0] OP_SRAV  = 5'd12;
  localparam logic [4:0] OP_LUI   = 5'd13;
  localparam logic [4:0] OP_MULT  = 5'd14;
  localparam logic [4:0] OP_MULTU = 5'd15;
  localparam logic [4:0] OP_DIV   = 5'd16;
  localparam logic [4:0] OP_DIVU  = 5'd17;
  localparam logic [4:0] OP_MFHI  = 5'd18;
  localparam logic [4:0] OP_MFLO  = 5'd19;

  // ALU-control decode: alu_op selects fixed add/sub, funct table or opcode table
  always_comb begin
    alu_ctrl = OP_ADD;
    case (alu_op)
      2'b00: alu_ctrl = OP_ADD;
      2'b01: alu_ctrl = OP_SUB;
      2'b10: begin
        case (funct)
          6'h21: alu_ctrl = OP_ADD;
          6'h23: alu_ctrl = OP_SUB;
          6'h24: alu_ctrl = OP_AND;
          6'h25: alu_ctrl = OP_OR;
          6'h26: alu_ctrl = OP_XOR;
          6'h2A: alu_ctrl = OP_SLT;
          6'h2B: alu_ctrl = OP_SLTU;
          6'h00: alu_ctrl = OP_SLL;
          6'h02: alu_ctrl = OP_SRL;
          6'h03: alu_ctrl = OP_SRA;
          6'h04: alu_ctrl = OP_SLLV;
          6'h06: alu_ctrl = OP_SRLV;
          6'h07: alu_ctrl = OP_SRAV;
          6'h18: alu_ctrl = OP_MULT;
          6'h19: alu_ctrl = OP_MULTU;
          6'h1A: alu_ctrl = OP_DIV;
          6'h1B: alu_ctrl = OP_DIVU;
          6'h10: alu_ctrl = OP_MFHI;
          6'h12: alu_ctrl = OP_MFLO;
          default: alu_ctrl = OP_ADD;
        endcase
      end
      default: begin
        case (opcode)
          6'h09: alu_ctrl = OP_ADD;
          6'h0A: alu_ctrl = OP_SLT;
          6'h0B: alu_ctrl = OP_SLTU;
          6'h0C: alu_ctrl = OP_AND;
          6'h0D: alu_ctrl = OP_OR;
          6'h0E: alu_ctrl = OP_XOR;
          6'h0F: alu_ctrl = OP_LUI;
          default: alu_ctrl = OP_ADD;
        endcase
      end
    endcase
  end

  // ALU result; multiply/divide ops only affect HI/LO so they drive zero here
  always_comb begin
    alu_out = 32'h0;
    case (alu_ctrl)
      OP_ADD:  alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_XOR:  alu_out = a ^ b;
      OP_SLT:  alu_out = {31'h0, ($signed(a) < $signed(b))};
      OP_SLTU: alu_out = {31'h0, (a < b)};
      OP_SLL:  alu_out = b << shamt;
      OP_SRL:  alu_out = b >> shamt;
      OP_SRA:  alu_out = $signed(b) >>> shamt;
      OP_SLLV: alu_out = b << a[4:0];
      OP_SRLV: alu_out = b >> a[4:0];
      OP_SRAV: alu_out = $signed(b) >>> a[4:0];
      OP_LUI:  alu_out = {b[15:0], 16'h0};
      OP_MFHI: alu_out = hi;
      OP_MFLO: alu_out = lo;
      default: alu_out = 32'h0;
    endcase
  end

  assign zero        = (alu_out == 32'h0);
  assign branch_addr = pc_plus4 + (immdt_32 << 2);

`ifdef ALU_MULDIV_EN
  logic signed [63:0] a_s64;
  logic signed [63:0] b_s64;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] next_hi;
  logic        [31:0] next_lo;
  logic               md_wr;

  assign a_s64  = {{32{a[31]}}, a};
  assign b_s64  = {{32{b[31]}}, b};
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Next HI/LO value; divide-by-zero and the single signed-overflow case are pinned explicitly
  always_comb begin
    next_hi = hi;
    next_lo = lo;
    md_wr   = 1'b1;
    case (alu_ctrl)
      OP_MULT:  {next_hi, next_lo} = prod_s;
      OP_MULTU: {next_hi, next_lo} = prod_u;
      OP_DIV: begin
        if (b == 32'h0) begin
          next_hi = a;
          next_lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          next_hi = 32'h0;
          next_lo = 32'h8000_0000;
        end else begin
          next_hi = $signed(a) % $signed(b);
          next_lo = $signed(a) / $signed(b);
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) begin
          next_hi = a;
          next_lo = 32'hFFFF_FFFF;
        end else begin
          next_hi = a % b;
          next_lo = a / b;
        end
      end
      default: md_wr = 1'b0;
    endcase
  end

  // HI/LO registers: reset wins over enable, written only by mult/div ops
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end else if (en && md_wr) begin
      hi <= next_hi;
      lo <= next_lo;
    end
  end
`else
  // Without the mult/div datapath HI/LO only ever hold zero
  always_ff @(posedge clk) begin
    if (reset || en) begin
      hi <= 32'h0;
      lo <= 32'h0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed and randomized checks of alu_exec_unit against a reference model
module tb_alu_exec_unit;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  opcode = 6'h0;
  logic [5:0]  funct = 6'h0;
  logic [4:0]  shamt = 5'h0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic [31:0] immdt_32 = 32'h0;
  logic [31:0] pc_plus4 = 32'h0;
  logic [31:0] alu_out;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] branch_addr;
  logic [4:0]  alu_ctrl;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  int funct_map[int];
  int opc_map[int];

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .opcode(opcode),
    .funct(funct), .shamt(shamt), .a(a), .b(b), .immdt_32(immdt_32),
    .pc_plus4(pc_plus4), .alu_out(alu_out), .zero(zero), .hi(hi), .lo(lo),
    .branch_addr(branch_addr), .alu_ctrl(alu_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int decode_ref();
    if (alu_op == 2'b00) return 0;
    if (alu_op == 2'b01) return 1;
    if (alu_op == 2'b10) return funct_map.exists(int'(funct)) ? funct_map[int'(funct)] : 0;
    return opc_map.exists(int'(opcode)) ? opc_map[int'(opcode)] : 0;
  endfunction

  function automatic logic [31:0] result_ref(input int code);
    int sb;
    int n;
    sb = int'(b);
    n = (code >= 10 && code <= 12) ? int'(a % 32) : int'(shamt);
    case (code)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      7, 10: return b << n;
      8, 11: return b >> n;
      9, 12: return 32'(sb >>> n);
      13: return b * 32'd65536;
      18: return m_hi;
      19: return m_lo;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int code;
    longint sa;
    longint sbb;
    longint q;
    longint r;
    logic [63:0] p;
    code = decode_ref();
    if (reset) begin
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else if (en && MD && code >= 14 && code <= 17) begin
      sa = int'(a);
      sbb = int'(b);
      if (code == 14) begin
        p = 64'(sa * sbb);
        m_hi = p[63:32]; m_lo = p[31:0];
      end else if (code == 15) begin
        p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end else if (b == 32'h0) begin
        m_hi = a; m_lo = 32'hFFFF_FFFF;
      end else if (code == 16) begin
        q = sa / sbb;
        r = sa % sbb;
        m_hi = 32'(r); m_lo = 32'(q);
      end else begin
        m_hi = a % b; m_lo = a / b;
      end
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] op, input logic [5:0] opc,
                       input logic [5:0] fn, input logic [4:0] sh, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] imm, input logic [31:0] pc);
    reset = r; en = e; alu_op = op; opcode = opc; funct = fn; shamt = sh;
    a = aa; b = bb; immdt_32 = imm; pc_plus4 = pc;
    #1;
  endtask

  task automatic check_model();
    logic [31:0] exp;
    int code;
    code = decode_ref();
    exp = result_ref(code);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(code));
    chk("alu_out", alu_out, exp);
    chk("zero", 32'(zero), (exp == 32'h0) ? 32'd1 : 32'd0);
    chk("branch_addr", branch_addr, pc_plus4 + immdt_32 * 32'd4);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    funct_map[6'h21] = 0;  funct_map[6'h23] = 1;  funct_map[6'h24] = 2;  funct_map[6'h25] = 3;
    funct_map[6'h26] = 4;  funct_map[6'h2A] = 5;  funct_map[6'h2B] = 6;  funct_map[6'h00] = 7;
    funct_map[6'h02] = 8;  funct_map[6'h03] = 9;  funct_map[6'h04] = 10; funct_map[6'h06] = 11;
    funct_map[6'h07] = 12; funct_map[6'h18] = 14; funct_map[6'h19] = 15; funct_map[6'h1A] = 16;
    funct_map[6'h1B] = 17; funct_map[6'h10] = 18; funct_map[6'h12] = 19;
    opc_map[6'h09] = 0; opc_map[6'h0A] = 5; opc_map[6'h0B] = 6; opc_map[6'h0C] = 2;
    opc_map[6'h0D] = 3; opc_map[6'h0E] = 4; opc_map[6'h0F] = 13;

    drive(1, 0, 2'b10, 6'h0, 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    drive(0, 1, 2'b10, 6'h0, 6'h21, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    chk("add_out", alu_out, 32'd1);
    chk("add_zero", 32'(zero), 32'd0);
    check_model(); tick();

    drive(0, 1, 2'b01, 6'h0, 6'h0, 5'd0, 32'd5, 32'd5, 32'h0, 32'h0);
    chk("sub_out", alu_out, 32'd0);
    chk("sub_zero", 32'(zero), 32'd1);
    check_model(); tick();

    drive(0, 1, 2'b10, 6'h0, 6'h03, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 32'h0);
    chk("sra", alu_out, 32'hF800_0000);
    check_model(); tick();

    drive(0, 1, 2'b10, 6'h0, 6'h06, 5'd0, 32'd36, 32'h8000_0000, 32'h0, 32'h0);
    chk("srlv", alu_out, 32'h0800_0000);
    check_model(); tick();

    drive(0, 1, 2'b10, 6'h0, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    chk("slt", alu_out, 32'd1);
    drive(0, 1, 2'b10, 6'h0, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    chk("sltu", alu_out, 32'd0);

    drive(0, 1, 2'b11, 6'h0F, 6'h0, 5'd0, 32'h0, 32'h0000_1234, 32'h0, 32'h0);
    chk("lui", alu_out, 32'h1234_0000);
    drive(0, 1, 2'b11, 6'h0D, 6'h0, 5'd0, 32'hF0, 32'h0F, 32'h0, 32'h0);
    chk("ori", alu_out, 32'hFF);
    check_model(); tick();

    drive(0, 1, 2'b10, 6'h0, 6'h18, 5'd0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
    chk("mult_out", alu_out, 32'h0);
    check_model(); tick();
    chk("mult_hi", hi, MD ? 32'hFFFF_FFFF : 32'h0);
    chk("mult_lo", lo, MD ? 32'hFFFF_FFFA : 32'h0);

    drive(0, 1, 2'b10, 6'h0, 6'h12, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("mflo", alu_out, MD ? 32'hFFFF_FFFA : 32'h0);
    check_model(); tick();

    drive(0, 0, 2'b10, 6'h0, 6'h18, 5'd0, 32'd100, 32'd100, 32'h0, 32'h0);
    tick();
    chk("frozen_hi", hi, MD ? 32'hFFFF_FFFF : 32'h0);
    chk("frozen_lo", lo, MD ? 32'hFFFF_FFFA : 32'h0);

    drive(0, 1, 2'b10, 6'h0, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
    tick();
    chk("div_hi", hi, MD ? 32'hFFFF_FFFF : 32'h0);
    chk("div_lo", lo, MD ? 32'hFFFF_FFFD : 32'h0);

    drive(0, 1, 2'b10, 6'h0, 6'h1A, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
    tick();
    chk("divovf_hi", hi, 32'h0);
    chk("divovf_lo", lo, MD ? 32'h8000_0000 : 32'h0);

    drive(0, 1, 2'b10, 6'h0, 6'h1B, 5'd0, 32'd9, 32'd0, 32'h0, 32'h0);
    tick();
    chk("divu0_hi", hi, MD ? 32'd9 : 32'h0);
    chk("divu0_lo", lo, MD ? 32'hFFFF_FFFF : 32'h0);

    drive(1, 0, 2'b10, 6'h0, 6'h10, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("rst_en0_hi", hi, 32'h0);
    chk("rst_en0_lo", lo, 32'h0);

    drive(0, 1, 2'b00, 6'h0, 6'h0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hBFC0_0004);
    chk("br_back", branch_addr, 32'hBFC0_0000);
    drive(0, 1, 2'b00, 6'h0, 6'h0, 5'd0, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFC);
    chk("br_wrap", branch_addr, 32'h0);
    check_model(); tick();

    for (int i = 0; i < 400; i++) begin
      logic [5:0] fn;
      logic [31:0] ra;
      logic [31:0] rb;
      case ($urandom_range(0, 3))
        0: fn = 6'($urandom_range(0, 63));
        1: fn = 6'h18 + 6'($urandom_range(0, 3));
        2: fn = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
        default: fn = 6'h21 + 6'($urandom_range(0, 10));
      endcase
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)), fn,
            5'($urandom_range(0, 31)), ra, rb, $urandom, $urandom);
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
